// File: rtl/vp_load_ctrl_if.sv
// Load-side bus between the MEM stage / predictor / D-cache and vp_load_ctrl.
// slave is the controller's view; master is the pipeline/environment view.
interface vp_load_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_ready;
  logic                  vp_pred_valid;
  logic [DATA_WIDTH-1:0] vp_pred_data;
  logic                  spec_valid;
  logic [DATA_WIDTH-1:0] spec_data;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  flush;
  logic                  train_valid;
  logic [ADDR_WIDTH-1:0] train_addr;
  logic [DATA_WIDTH-1:0] train_data;
  logic                  recover_req;
  logic [DATA_WIDTH-1:0] recover_data;
  logic                  recover_ack;
  logic                  done;
  logic                  throttled;

  modport master (
    output ld_valid, ld_addr, vp_pred_valid, vp_pred_data,
           mem_valid, mem_data, flush, recover_ack,
    input  ld_ready, spec_valid, spec_data, train_valid, train_addr,
           train_data, recover_req, recover_data, done, throttled
  );

  modport slave (
    input  ld_valid, ld_addr, vp_pred_valid, vp_pred_data,
           mem_valid, mem_data, flush, recover_ack,
    output ld_ready, spec_valid, spec_data, train_valid, train_addr,
           train_data, recover_req, recover_data, done, throttled
  );
endinterface

// File: rtl/vp_load_ctrl.sv
// Value-prediction load sequencer: speculative forward, verify/train, recovery, throttling.
// Optional VP_LOAD_CTRL_STATS_EN adds saturating stat_pred/stat_hit/stat_miss counters.
module vp_load_ctrl #(
  parameter int MISS_LIMIT = 3,
  parameter int COOLDOWN   = 64,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  vp_load_ctrl_if.slave  bus
`ifdef VP_LOAD_CTRL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_pred,
  output logic [CNT_WIDTH-1:0] stat_hit,
  output logic [CNT_WIDTH-1:0] stat_miss
`endif
);

  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam int CW = $clog2(COOLDOWN + 1);

  if (MISS_LIMIT < 1 || COOLDOWN < 1 || CNT_WIDTH < 1) begin : g_bad_params
    $error("vp_load_ctrl: MISS_LIMIT, COOLDOWN and CNT_WIDTH must all be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SPEC_WAIT, PLAIN_WAIT, RECOVER} state_t;

  state_t                state_q, state_d;
  logic [MW-1:0]         miss_cnt_q, miss_cnt_d;
  logic [CW-1:0]         cool_cnt_q, cool_cnt_d;
  logic                  drop_pending_q, drop_pending_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] pred_q, pred_d;
  logic [DATA_WIDTH-1:0] rec_data_q, rec_data_d;

  logic throttled_i, ready_i, accept, take_pred;
  logic train_i, done_i, hit_evt, miss_evt;

  always_comb begin
    state_d        = state_q;
    miss_cnt_d     = miss_cnt_q;
    cool_cnt_d     = cool_cnt_q;
    drop_pending_d = drop_pending_q;
    addr_d         = addr_q;
    pred_d         = pred_q;
    rec_data_d     = rec_data_q;
    train_i        = 1'b0;
    done_i         = 1'b0;
    hit_evt        = 1'b0;
    miss_evt       = 1'b0;

    throttled_i = (cool_cnt_q != '0);
    ready_i     = (state_q == IDLE) && !drop_pending_q;
    // A flush in the accept cycle kills the load before it is tracked.
    accept      = bus.ld_valid && ready_i && !bus.flush;
    take_pred   = accept && bus.vp_pred_valid && !throttled_i;

    // Cooldown runs regardless of FSM state; expiry also forgives past misses.
    if (throttled_i) begin
      cool_cnt_d = cool_cnt_q - CW'(1);
      if (cool_cnt_q == CW'(1)) miss_cnt_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (drop_pending_q) begin
          if (bus.mem_valid) drop_pending_d = 1'b0;
        end else if (accept) begin
          addr_d = bus.ld_addr;
          if (take_pred) begin
            pred_d  = bus.vp_pred_data;
            state_d = SPEC_WAIT;
          end else begin
            state_d = PLAIN_WAIT;
          end
        end
      end
      SPEC_WAIT: begin
        if (bus.flush) begin
          state_d        = IDLE;
          drop_pending_d = !bus.mem_valid;
        end else if (bus.mem_valid) begin
          train_i = 1'b1;
          if (bus.mem_data == pred_q) begin
            hit_evt    = 1'b1;
            done_i     = 1'b1;
            miss_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            miss_evt   = 1'b1;
            rec_data_d = bus.mem_data;
            if (miss_cnt_q != MW'(MISS_LIMIT)) miss_cnt_d = miss_cnt_q + MW'(1);
            state_d    = RECOVER;
          end
        end
      end
      PLAIN_WAIT: begin
        if (bus.flush) begin
          state_d        = IDLE;
          drop_pending_d = !bus.mem_valid;
        end else if (bus.mem_valid) begin
          train_i = 1'b1;
          done_i  = 1'b1;
          state_d = IDLE;
        end
      end
      RECOVER: begin
        if (bus.recover_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (miss_evt && miss_cnt_d == MW'(MISS_LIMIT)) cool_cnt_d = CW'(COOLDOWN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      miss_cnt_q     <= '0;
      cool_cnt_q     <= '0;
      drop_pending_q <= 1'b0;
      addr_q         <= '0;
      pred_q         <= '0;
      rec_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      miss_cnt_q     <= miss_cnt_d;
      cool_cnt_q     <= cool_cnt_d;
      drop_pending_q <= drop_pending_d;
      addr_q         <= addr_d;
      pred_q         <= pred_d;
      rec_data_q     <= rec_data_d;
    end
  end

  // Every output is forced low while reset is asserted.
  assign bus.ld_ready     = rst_n && ready_i;
  assign bus.spec_valid   = rst_n && take_pred;
  assign bus.spec_data    = (rst_n && take_pred) ? bus.vp_pred_data : '0;
  assign bus.train_valid  = rst_n && train_i;
  assign bus.train_addr   = (rst_n && train_i) ? addr_q : '0;
  assign bus.train_data   = (rst_n && train_i) ? bus.mem_data : '0;
  assign bus.recover_req  = rst_n && (state_q == RECOVER);
  assign bus.recover_data = rst_n ? rec_data_q : '0;
  assign bus.done         = rst_n && done_i;
  assign bus.throttled    = rst_n && throttled_i;

`ifdef VP_LOAD_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] stat_pred_q, stat_pred_d;
  logic [CNT_WIDTH-1:0] stat_hit_q, stat_hit_d;
  logic [CNT_WIDTH-1:0] stat_miss_q, stat_miss_d;

  always_comb begin
    stat_pred_d = stat_pred_q;
    stat_hit_d  = stat_hit_q;
    stat_miss_d = stat_miss_q;
    if (take_pred && stat_pred_q != '1) stat_pred_d = stat_pred_q + CNT_WIDTH'(1);
    if (hit_evt   && stat_hit_q  != '1) stat_hit_d  = stat_hit_q  + CNT_WIDTH'(1);
    if (miss_evt  && stat_miss_q != '1) stat_miss_d = stat_miss_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_pred_q <= '0;
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else begin
      stat_pred_q <= stat_pred_d;
      stat_hit_q  <= stat_hit_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign stat_pred = rst_n ? stat_pred_q : '0;
  assign stat_hit  = rst_n ? stat_hit_q  : '0;
  assign stat_miss = rst_n ? stat_miss_q : '0;
`endif

endmodule

// File: tb/tb_vp_load_ctrl.sv
// Scoreboard bench for vp_load_ctrl: train/recover expectations queued at stimulus time,
// popped by a negedge monitor; handshake/throttle timing checked inline.
module tb_vp_load_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vp_load_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef VP_LOAD_CTRL_STATS_EN
  logic [15:0] stat_pred, stat_hit, stat_miss;
`endif

  vp_load_ctrl #(.MISS_LIMIT(3), .COOLDOWN(64), .CNT_WIDTH(16),
                 .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef VP_LOAD_CTRL_STATS_EN
    ,
    .stat_pred (stat_pred),
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } train_t;

  train_t      train_q[$];
  logic [31:0] rec_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  int thr_rise = 0;
  int thr_len  = -1;
  logic thr_fell = 1'b0;
  logic rec_prev = 1'b0;
  logic thr_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: consumes expected train/recover transactions as the DUT produces them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.train_valid) begin
        if (train_q.size() == 0) begin
          chk("train_unexpected", 32'd1, 32'd0);
        end else begin
          train_t t;
          t = train_q.pop_front();
          chk("train_addr", bus.train_addr, t.addr);
          chk("train_data", bus.train_data, t.data);
          $display("train addr=0x%0h data=0x%0h", bus.train_addr, bus.train_data);
        end
      end
      if (bus.recover_req && !rec_prev) begin
        if (rec_q.size() == 0) begin
          chk("recover_unexpected", 32'd1, 32'd0);
        end else begin
          logic [31:0] r;
          r = rec_q.pop_front();
          chk("recover_data", bus.recover_data, r);
          $display("recover data=0x%0h", bus.recover_data);
        end
      end
      if (bus.throttled && !thr_prev) thr_rise <= cyc_cnt;
      if (!bus.throttled && thr_prev) begin
        thr_len  <= cyc_cnt - thr_rise;
        thr_fell <= 1'b1;
      end
    end
    rec_prev <= bus.recover_req;
    thr_prev <= bus.throttled;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic pv, input logic [31:0] pred,
                         input logic exp_spec);
    bus.ld_valid      = 1'b1;
    bus.ld_addr       = addr;
    bus.vp_pred_valid = pv;
    bus.vp_pred_data  = pred;
    @(negedge clk);
    chk("ld_ready_accept", {31'd0, bus.ld_ready}, 32'd1);
    chk("spec_valid", {31'd0, bus.spec_valid}, {31'd0, exp_spec});
    chk("spec_data", bus.spec_data, exp_spec ? pred : 32'd0);
    $display("load addr=0x%0h pred_valid=%0d pred=0x%0h spec=%0d", addr, pv, pred, bus.spec_valid);
    tick();
    bus.ld_valid      = 1'b0;
    bus.vp_pred_valid = 1'b0;
  endtask

  task automatic do_resp(input logic [31:0] data, input logic exp_done);
    bus.mem_valid = 1'b1;
    bus.mem_data  = data;
    @(negedge clk);
    chk("done", {31'd0, bus.done}, {31'd0, exp_done});
    $display("resp data=0x%0h done=%0d", data, bus.done);
    tick();
    bus.mem_valid = 1'b0;
  endtask

  // Entered in the first RECOVER cycle; leaves one cycle after ack with IDLE confirmed.
  task automatic do_recover(input int hold, input logic exp_thr);
    @(negedge clk);
    chk("throttled_after_miss", {31'd0, bus.throttled}, {31'd0, exp_thr});
    for (int i = 0; i < hold; i++) begin
      if (i > 0) @(negedge clk);
      chk("recover_req_held", {31'd0, bus.recover_req}, 32'd1);
      chk("ld_ready_recover", {31'd0, bus.ld_ready}, 32'd0);
      tick();
    end
    bus.recover_ack = 1'b1;
    @(negedge clk);
    chk("recover_req_at_ack", {31'd0, bus.recover_req}, 32'd1);
    tick();
    bus.recover_ack = 1'b0;
    @(negedge clk);
    chk("recover_req_cleared", {31'd0, bus.recover_req}, 32'd0);
    chk("ld_ready_after_ack", {31'd0, bus.ld_ready}, 32'd1);
    $display("recover acked");
    tick();
  endtask

  task automatic mispredict(input logic [31:0] addr, input logic [31:0] pred,
                            input logic [31:0] actual, input int hold, input logic exp_thr);
    do_load(addr, 1'b1, pred, 1'b1);
    train_q.push_back('{addr: addr, data: actual});
    rec_q.push_back(actual);
    do_resp(actual, 1'b0);
    do_recover(hold, exp_thr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ld_valid = 1'b0;      bus.ld_addr = '0;
    bus.vp_pred_valid = 1'b0; bus.vp_pred_data = '0;
    bus.mem_valid = 1'b0;     bus.mem_data = '0;
    bus.flush = 1'b0;         bus.recover_ack = 1'b0;

    // Reset: all outputs low while rst_n is low
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("rst_spec_valid", {31'd0, bus.spec_valid}, 32'd0);
    chk("rst_recover_req", {31'd0, bus.recover_req}, 32'd0);
    chk("rst_throttled", {31'd0, bus.throttled}, 32'd0);
    chk("rst_train_valid", {31'd0, bus.train_valid}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ld_ready_post_reset", {31'd0, bus.ld_ready}, 32'd1);
    tick();

    // Correct prediction
    do_load(32'h100, 1'b1, 32'h1234, 1'b1);
    train_q.push_back('{addr: 32'h100, data: 32'h1234});
    do_resp(32'h1234, 1'b1);
    @(negedge clk);
    chk("no_recover_on_hit", {31'd0, bus.recover_req}, 32'd0);
    chk("ld_ready_after_hit", {31'd0, bus.ld_ready}, 32'd1);
    tick();

    // Mispredict with 3-cycle ack delay (miss 1 of 3)
    mispredict(32'h104, 32'hAAAA, 32'h5555, 3, 1'b0);
    // Two more consecutive misses; the third throttles
    mispredict(32'h108, 32'h1111, 32'h2222, 1, 1'b0);
    mispredict(32'h10C, 32'h3333, 32'h4444, 1, 1'b1);

    // Throttled: predicted load goes plain
    do_load(32'h110, 1'b1, 32'h7777, 1'b0);
    train_q.push_back('{addr: 32'h110, data: 32'h8888});
    do_resp(32'h8888, 1'b1);
    for (int i = 0; i < 200 && !thr_fell; i++) tick();
    chk("throttle_len", thr_len, 32'd64);
    $display("throttle length=%0d cycles", thr_len);

    // Cooldown expiry also cleared the miss count: one miss must not re-throttle
    mispredict(32'h114, 32'h0001, 32'h0002, 1, 1'b0);

    // Flush in SPEC_WAIT, response arrives two cycles later and is dropped
    do_load(32'h200, 1'b1, 32'h77, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_done", {31'd0, bus.done}, 32'd0);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("drop_ld_ready_0", {31'd0, bus.ld_ready}, 32'd0);
    tick();
    do_resp(32'h77, 1'b0);
    @(negedge clk);
    chk("drop_cleared_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    tick();

    // Flush and response together in PLAIN_WAIT: consumed, no drop pending
    do_load(32'h300, 1'b0, 32'h0, 1'b0);
    bus.flush = 1'b1;
    do_resp(32'h99, 1'b0);
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_mem_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    tick();

    // Flush in IDLE with ld_valid: no accept
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h400;
    bus.vp_pred_valid = 1'b1; bus.vp_pred_data = 32'h55;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_spec", {31'd0, bus.spec_valid}, 32'd0);
    tick();
    bus.ld_valid = 1'b0; bus.vp_pred_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_not_accepted", {31'd0, bus.ld_ready}, 32'd1);
    tick();

    // Reset while in RECOVER: recovery abandoned, late response ignored
    do_load(32'h500, 1'b1, 32'hCAFE, 1'b1);
    train_q.push_back('{addr: 32'h500, data: 32'hBEEF});
    rec_q.push_back(32'hBEEF);
    do_resp(32'hBEEF, 1'b0);
    @(negedge clk);
    chk("recover_before_reset", {31'd0, bus.recover_req}, 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_recover_req", {31'd0, bus.recover_req}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_recover_req_after", {31'd0, bus.recover_req}, 32'd0);
    tick();
    do_resp(32'hBEEF, 1'b0);
    @(negedge clk);
    chk("post_reset_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    tick();

    // Normal hit still works after mid-operation reset
    do_load(32'h600, 1'b1, 32'h600D, 1'b1);
    train_q.push_back('{addr: 32'h600, data: 32'h600D});
    do_resp(32'h600D, 1'b1);
    tick();

    chk("train_q_empty", train_q.size(), 32'd0);
    chk("rec_q_empty", rec_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
